// File: rtl/masked_sbox_pkg.sv
// +--------------------------------------------------------------------------+
// | masked_sbox_pkg : shared types and constants for the masked S-box issue  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package masked_sbox_pkg;

  localparam int SHARE_W      = 8;
  localparam int SBOX_LAT_DEF = 2;
  localparam int RND_W_DEF    = 8;
  // Tag ID field is sized for up to 256 requesters; users truncate to IDW.
  localparam int TAG_ID_W     = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/masked_sbox_scheduler_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | masked_sbox_scheduler_rr_arbiter : cyclic first-set search from ptr+1    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module masked_sbox_scheduler_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/masked_sbox_scheduler.sv
// +--------------------------------------------------------------------------+
// | masked_sbox_scheduler : round-robin issue of masked bytes + fresh        |
// | randomness into a shared pipelined S-box, with ID tracking. Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module masked_sbox_scheduler
  import masked_sbox_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SBOX_LAT = SBOX_LAT_DEF,
  parameter int RND_W    = RND_W_DEF,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [SHARE_W*NREQ-1:0] req_in0,
  input  logic [SHARE_W*NREQ-1:0] req_in1,
  input  logic                    rnd_valid,
  output logic                    rnd_ready,
  input  logic [RND_W-1:0]        rnd,
  output logic [SHARE_W-1:0]      sb_in0,
  output logic [SHARE_W-1:0]      sb_in1,
  output logic [RND_W-1:0]        sb_r,
  input  logic [SHARE_W-1:0]      sb_out0,
  input  logic [SHARE_W-1:0]      sb_out1,
  output logic                    res_valid,
  output logic [IDW-1:0]          res_id,
  output logic [SHARE_W-1:0]      res_out0,
  output logic [SHARE_W-1:0]      res_out1,
  output logic                    busy
);

  logic [NREQ-1:0]    gnt_onehot;
  logic [IDW-1:0]     gnt_id;
  logic               issue;
  logic [SHARE_W-1:0] lane0 [NREQ];
  logic [SHARE_W-1:0] lane1 [NREQ];

  logic [IDW-1:0]     ptr_q,    ptr_d;
  logic [SHARE_W-1:0] sb_in0_q, sb_in0_d;
  logic [SHARE_W-1:0] sb_in1_q, sb_in1_d;
  logic [RND_W-1:0]   sb_r_q,   sb_r_d;
  tag_t               tag_d;
  tag_t               tag_q [SBOX_LAT+1];
  logic               busy_w;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane0[i] = req_in0[i*SHARE_W +: SHARE_W];
    assign lane1[i] = req_in1[i*SHARE_W +: SHARE_W];
  end

  masked_sbox_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt_onehot),
    .gnt_id_o (gnt_id)
  );

  // rst_n gates the handshake so nothing is acknowledged while held in reset.
  assign issue     = rst_n & en & rnd_valid & (|req_valid);
  assign req_ready = {NREQ{issue}} & gnt_onehot;
  assign rnd_ready = issue;

  always_comb begin
    ptr_d    = ptr_q;
    sb_in0_d = '0;
    sb_in1_d = '0;
    sb_r_d   = '0;
    tag_d    = '0;
    if (issue) begin
      ptr_d       = gnt_id;
      sb_in0_d    = lane0[gnt_id];
      sb_in1_d    = lane1[gnt_id];
      sb_r_d      = rnd;
      tag_d.valid = 1'b1;
      tag_d.id    = TAG_ID_W'(gnt_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= IDW'(NREQ - 1);
      sb_in0_q <= '0;
      sb_in1_q <= '0;
      sb_r_q   <= '0;
      for (int k = 0; k <= SBOX_LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      sb_in0_q <= sb_in0_d;
      sb_in1_q <= sb_in1_d;
      sb_r_q   <= sb_r_d;
      tag_q[0] <= tag_d;
      for (int k = 1; k <= SBOX_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    busy_w = 1'b0;
    for (int k = 0; k <= SBOX_LAT; k++) busy_w = busy_w | tag_q[k].valid;
  end

  assign sb_in0    = sb_in0_q;
  assign sb_in1    = sb_in1_q;
  assign sb_r      = sb_r_q;
  assign res_valid = tag_q[SBOX_LAT].valid;
  assign res_id    = IDW'(tag_q[SBOX_LAT].id);
  assign res_out0  = sb_out0;
  assign res_out1  = sb_out1;
  assign busy      = busy_w;

endmodule

`default_nettype wire

// File: tb/tb_masked_sbox_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_masked_sbox_scheduler : bench with S-box model and queue-based ref    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_masked_sbox_scheduler;

  localparam int NREQ     = 4;
  localparam int SBOX_LAT = 2;
  localparam int RND_W    = 8;
  localparam int IDW      = 2;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_in0;
  logic [8*NREQ-1:0]   req_in1;
  logic                rnd_valid;
  logic                rnd_ready;
  logic [RND_W-1:0]    rnd;
  logic [7:0]          sb_in0, sb_in1;
  logic [RND_W-1:0]    sb_r;
  logic [7:0]          sb_out0, sb_out1;
  logic                res_valid;
  logic [IDW-1:0]      res_id;
  logic [7:0]          res_out0, res_out1;
  logic                busy;

  masked_sbox_scheduler #(
    .NREQ     (NREQ),
    .SBOX_LAT (SBOX_LAT),
    .RND_W    (RND_W),
    .IDW      (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd       (rnd),
    .sb_in0    (sb_in0),
    .sb_in1    (sb_in1),
    .sb_r      (sb_r),
    .sb_out0   (sb_out0),
    .sb_out1   (sb_out1),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_out0  (res_out0),
    .res_out1  (res_out1),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference AES S-box from GF(2^8) inverse and affine map.
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h00;
      if (v != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Masked S-box stand-in: share0 = S(x)^r, share1 = r, SBOX_LAT deep.
  logic [7:0] p0 [SBOX_LAT];
  logic [7:0] p1 [SBOX_LAT];
  always @(posedge clk) begin
    p0[0] <= sbox_tab[sb_in0 ^ sb_in1] ^ sb_r;
    p1[0] <= sb_r;
    for (int k = 1; k < SBOX_LAT; k++) begin
      p0[k] <= p0[k-1];
      p1[k] <= p1[k-1];
    end
  end
  assign sb_out0 = p0[SBOX_LAT-1];
  assign sb_out1 = p1[SBOX_LAT-1];

  typedef struct { int due; int id; logic [7:0] y; } exp_t;
  typedef struct { int cyc; int id; logic [7:0] y; } seen_t;
  typedef struct {
    logic en; logic rv; logic [NREQ-1:0] req; logic [NREQ-1:0] exp_rdy; logic exp_rnd;
  } vec_t;

  exp_t       expq [$];
  seen_t      seen [$];
  int         ptr_m;
  logic [7:0] last_in0, last_in1;
  logic [7:0] last_r;
  int         cyc_n;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    ptr_m    = NREQ - 1;
    expq.delete();
    last_in0 = 8'h00;
    last_in1 = 8'h00;
    last_r   = 8'h00;
  endtask

  // One clock cycle: drive, check everything against the model, advance.
  task automatic cyc(input logic e, input logic rv, input logic [NREQ-1:0] rq,
                     output logic [NREQ-1:0] rdy, output logic rr);
    int              g;
    logic            iss;
    logic [NREQ-1:0] exp_rdy;
    logic [7:0]      a0, a1;
    en = e; rnd_valid = rv; req_valid = rq;
    #1;
    iss = e && rv && (rq != '0);
    g = -1;
    if (iss)
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (ptr_m + k) % NREQ;
        if (g < 0 && rq[i]) g = i;
      end
    exp_rdy = '0;
    if (iss) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("rnd_ready", rnd_ready, iss);
    chk("sb_in0", sb_in0, last_in0);
    chk("sb_in1", sb_in1, last_in1);
    chk("sb_r", sb_r, last_r);
    chk("busy", busy, expq.size() != 0);
    if (expq.size() > 0 && expq[0].due == cyc_n) begin
      chk("res_valid", res_valid, 1);
      chk("res_id", res_id, expq[0].id);
      chk("res_data", res_out0 ^ res_out1, expq[0].y);
      void'(expq.pop_front());
    end else begin
      chk("res_valid_idle", res_valid, 0);
    end
    chk("res_passthru", {res_out0, res_out1}, {sb_out0, sb_out1});
    if (res_valid) seen.push_back('{cyc: cyc_n, id: int'(res_id), y: res_out0 ^ res_out1});
    rdy = req_ready;
    rr  = rnd_ready;
    if (iss) begin
      a0 = req_in0[8*g +: 8];
      a1 = req_in1[8*g +: 8];
      expq.push_back('{due: cyc_n + 1 + SBOX_LAT, id: g, y: sbox_tab[a0 ^ a1]});
      last_in0 = a0; last_in1 = a1; last_r = rnd; ptr_m = g;
    end else begin
      last_in0 = 8'h00; last_in1 = 8'h00; last_r = 8'h00;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (iss) rnd = RND_W'($urandom);
  endtask

  task automatic do_reset();
    en = 1'b1; rnd_valid = 1'b1; req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rnd_ready", rnd_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sb", {sb_in0, sb_in1, sb_r}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_n++;
    model_reset();
  endtask

  task automatic set_lanes_idx();
    for (int i = 0; i < NREQ; i++) begin
      logic [7:0] m;
      m = 8'($urandom);
      req_in0[8*i +: 8] = m;
      req_in1[8*i +: 8] = m ^ 8'(i);
    end
  endtask

  vec_t            tbl [17];
  logic [7:0]      exp_y [4];
  logic [NREQ-1:0] rdy;
  logic            rr;
  int              t0;

  initial begin
    n_tests = 0; n_fail = 0; cyc_n = 0;
    rst_n = 1'b1; en = 1'b0; rnd_valid = 1'b0; req_valid = '0;
    req_in0 = '0; req_in1 = '0; rnd = RND_W'($urandom);
    build_sbox();
    model_reset();
    exp_y = '{8'h63, 8'h7c, 8'h77, 8'h7b};
    tbl[0]  = '{1, 1, 4'b1111, 4'b0001, 1};
    tbl[1]  = '{1, 1, 4'b1111, 4'b0010, 1};
    tbl[2]  = '{1, 1, 4'b1111, 4'b0100, 1};
    tbl[3]  = '{1, 1, 4'b1111, 4'b1000, 1};
    tbl[4]  = '{1, 1, 4'b1111, 4'b0001, 1};
    tbl[5]  = '{1, 1, 4'b1111, 4'b0010, 1};
    tbl[6]  = '{1, 1, 4'b1111, 4'b0100, 1};
    tbl[7]  = '{1, 1, 4'b1111, 4'b1000, 1};
    tbl[8]  = '{1, 0, 4'b0110, 4'b0000, 0};
    tbl[9]  = '{1, 0, 4'b0110, 4'b0000, 0};
    tbl[10] = '{1, 0, 4'b0110, 4'b0000, 0};
    tbl[11] = '{1, 1, 4'b0110, 4'b0010, 1};
    tbl[12] = '{0, 1, 4'b1111, 4'b0000, 0};
    tbl[13] = '{1, 1, 4'b1001, 4'b1000, 1};
    tbl[14] = '{1, 1, 4'b1001, 4'b0001, 1};
    tbl[15] = '{1, 1, 4'b0000, 4'b0000, 0};
    tbl[16] = '{1, 1, 4'b0100, 4'b0100, 1};
    #2;
    do_reset();

    // Single request on lane 0, x = 0x53 -> S(x) = 0xED after 3 cycles.
    set_lanes_idx();
    req_in0[7:0] = 8'h5a;
    req_in1[7:0] = 8'h09;
    seen.delete();
    t0 = cyc_n;
    cyc(1, 1, 4'b0001, rdy, rr);
    chk("single_grant", rdy, 4'b0001);
    repeat (3) cyc(1, 1, 4'b0000, rdy, rr);
    chk("single_count", seen.size(), 1);
    if (seen.size() >= 1) begin
      chk("single_latency", seen[0].cyc - t0, 3);
      chk("single_id", seen[0].id, 0);
      chk("single_value", seen[0].y, 8'hed);
    end

    // Table: burst, randomness gap, enable gap, wraparound from ptr.
    do_reset();
    set_lanes_idx();
    seen.delete();
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].en, tbl[i].rv, tbl[i].req, rdy, rr);
      chk($sformatf("tbl%0d_req_ready", i), rdy, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_rnd_ready", i), rr, tbl[i].exp_rnd);
    end
    repeat (4) cyc(1, 1, 4'b0000, rdy, rr);
    chk("burst_count", seen.size() >= 8, 1);
    if (seen.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("burst%0d_id", i), seen[i].id, i % 4);
        chk($sformatf("burst%0d_y", i), seen[i].y, exp_y[i % 4]);
        chk($sformatf("burst%0d_cyc", i), seen[i].cyc - seen[0].cyc, i);
      end

    // Enable dropped after two issues: both drain, nothing new is accepted.
    seen.delete();
    repeat (2) cyc(1, 1, 4'b1111, rdy, rr);
    repeat (6) begin
      cyc(0, 1, 4'b1111, rdy, rr);
      chk("en_low_ready", rdy, 0);
    end
    chk("en_drop_count", seen.size(), 2);
    chk("en_drop_busy", busy, 0);

    // Reset with two operations in flight: results discarded, lane 0 first.
    repeat (2) cyc(1, 1, 4'b1111, rdy, rr);
    seen.delete();
    do_reset();
    repeat (3) cyc(0, 1, 4'b0000, rdy, rr);
    chk("rst_flush_count", seen.size(), 0);
    cyc(1, 1, 4'b1001, rdy, rr);
    chk("rst_lane0_first", rdy, 4'b0001);

    // Random traffic against the reference model.
    repeat (400) begin
      req_in0 = {$urandom, $urandom};
      req_in1 = {$urandom, $urandom};
      cyc(($urandom % 5) != 0, ($urandom % 4) != 0, NREQ'($urandom), rdy, rr);
    end
    repeat (6) cyc(0, 0, 4'b0000, rdy, rr);
    chk("final_drain", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
